// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the PC sequencer and its redirect hold register.
package pc_seq_pkg;
  localparam int unsigned     DEF_WIDTH        = 64;
  localparam int unsigned     DEF_INC          = 4;
  localparam longint unsigned DEF_RESET_VECTOR = 64'h0;

  typedef enum logic [1:0] {BOOT, RUN, HOLD, HALTED} pc_state_e;
  typedef enum logic [1:0] {NONE, BR, EXC} redir_kind_e;
endpackage

// File: rtl/pc_redirect_hold.sv
// Pending redirect target/kind register; an exception may replace anything,
// a branch may only replace a pending branch. eff_* shows the value after this cycle's requests.
module pc_redirect_hold
  import pc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             upd_i,
  input  logic             clr_i,
  input  logic             exc_req_i,
  input  logic [WIDTH-1:0] exc_vec_i,
  input  logic             br_req_i,
  input  logic [WIDTH-1:0] br_tgt_i,
  output redir_kind_e      eff_kind_o,
  output logic [WIDTH-1:0] eff_tgt_o
);
  redir_kind_e      kind_q, kind_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;

  always_comb begin
    eff_kind_o = kind_q;
    eff_tgt_o  = tgt_q;
    if (exc_req_i) begin
      eff_kind_o = EXC;
      eff_tgt_o  = exc_vec_i;
    end else if (br_req_i && kind_q != EXC) begin
      eff_kind_o = BR;
      eff_tgt_o  = br_tgt_i;
    end
  end

  always_comb begin
    kind_d = kind_q;
    tgt_d  = tgt_q;
    if (clr_i) begin
      kind_d = NONE;
      tgt_d  = '0;
    end else if (upd_i) begin
      kind_d = eff_kind_o;
      tgt_d  = eff_tgt_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      kind_q <= NONE;
      tgt_q  <= '0;
    end else begin
      kind_q <= kind_d;
      tgt_q  <= tgt_d;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot, increment, branch/exception redirect with stall-time capture, halt.
// Define PC_ALIGN_CHECK_EN to force loaded targets to 4-byte alignment and flag it on Misalign.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter int unsigned      INC          = DEF_INC
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             Br_Taken,
  input  logic [WIDTH-1:0] Br_Target,
  input  logic             Exc_Req,
  input  logic [WIDTH-1:0] Exc_Vector,
  output logic [WIDTH-1:0] Q,
  output logic             Q_Valid,
  output logic             Pend,
  output logic             Misalign
);
  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             redirect, load, hold_upd, hold_clr;
  redir_kind_e      eff_kind;
  logic [WIDTH-1:0] eff_tgt, load_val;

  assign redirect = Exc_Req | Br_Taken;

  // With nothing pending the effective target is simply the highest-priority live request.
  pc_redirect_hold #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst_n_i    (Reset),
    .upd_i      (hold_upd),
    .clr_i      (hold_clr),
    .exc_req_i  (Exc_Req),
    .exc_vec_i  (Exc_Vector),
    .br_req_i   (Br_Taken),
    .br_tgt_i   (Br_Target),
    .eff_kind_o (eff_kind),
    .eff_tgt_o  (eff_tgt)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign load_val   = {eff_tgt[WIDTH-1:2], 2'b00};
  assign misalign_d = load && (eff_tgt[1:0] != 2'b00);
  assign Misalign   = misalign_q;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`else
  assign load_val = eff_tgt;
  assign Misalign = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    load     = 1'b0;
    hold_upd = 1'b0;
    hold_clr = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect && Stall) begin
          hold_upd = 1'b1;
          state_d  = HOLD;
        end else if (redirect) begin
          load = 1'b1;
        end else if (!Stall) begin
          if (Halt) state_d = HALTED;
          else      q_d     = q_q + WIDTH'(INC);
        end
      end
      HOLD: begin
        hold_upd = 1'b1;
        if (!Stall) begin
          load     = 1'b1;
          hold_clr = 1'b1;
          state_d  = RUN;
        end
      end
      HALTED: begin
        if (Exc_Req) begin
          load    = 1'b1;
          state_d = RUN;
        end else if (!Halt) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    if (load) q_d = load_val;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= BOOT;
      q_q     <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
    end
  end

  assign Q       = q_q;
  assign Q_Valid = (state_q == RUN) || (state_q == HOLD);
  assign Pend    = (state_q == HOLD) && (eff_kind != NONE || !Stall || redirect);
endmodule
